// File: rtl/clock_enable_gen_if.sv
// clock_enable_gen_if
//   Bundles the control and strobe signals of clock_enable_gen.
//   master : the controlling side (drives lock, increments, run mask, sync)
//   slave  : the generator (returns enable strobes and ready)
//
//   locked : PLL lock, asynchronous to the generator clock
//   inc    : packed per-channel increments, channel i at [i*ACC_W +: ACC_W]
//   run    : per-channel enable
//   sync   : synchronous phase clear of all accumulators
//   ce     : registered single-cycle enable strobes
//   ready  : registered release-from-reset flag
interface clock_enable_gen_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ACC_W    = 24
);
    logic                         locked;
    logic [CHANNELS*ACC_W-1:0]    inc;
    logic [CHANNELS-1:0]          run;
    logic                         sync;
    logic [CHANNELS-1:0]          ce;
    logic                         ready;

    modport master (
        output locked,
        output inc,
        output run,
        output sync,
        input  ce,
        input  ready
    );

    modport slave (
        input  locked,
        input  inc,
        input  run,
        input  sync,
        output ce,
        output ready
    );
endinterface

// File: rtl/clock_enable_gen.sv
// clock_enable_gen
//   Multi-channel fractional clock-enable generator. Each channel owns an
//   ACC_W-bit phase accumulator; the carry out of accumulator + increment is
//   registered as a one-cycle enable strobe, so the average strobe rate is
//   f_clock * inc / 2^ACC_W with at most one clock of jitter. A lock
//   synchroniser and hold counter produce 'ready', which also gates every
//   accumulator so no strobe is ever emitted before the PLL is stable.
//
//   clock : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : clock_enable_gen_if.slave (locked, inc, run, sync -> ce, ready)
module clock_enable_gen #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    clock_enable_gen_if.slave  bus
);

    localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_HOLD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Lock synchroniser; lk2 is the only internal view of 'locked'.
    logic lk1_q, lk1_d;
    logic lk2_q, lk2_d;

    // Hold counter and ready FSM.
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    state_t            state_q, state_d;

    // Per-channel phase accumulators and registered strobes.
    logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0]            ce_q, ce_d;
    logic [CHANNELS-1:0][ACC_W:0]   sum_c;
    logic                           clear_all_c;

    // Synchroniser next state.
    always_comb begin
        lk1_d = bus.locked;
        lk2_d = lk1_q;
    end

    // Hold counter and ready FSM next state: count stable-lock edges, freeze
    // once ready, drop back to HOLD as soon as the synchronised lock falls.
    always_comb begin
        hcnt_d  = hcnt_q;
        state_d = state_q;
        if (!lk2_q) begin
            hcnt_d  = '0;
            state_d = ST_HOLD;
        end else if (state_q == ST_HOLD) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
            if (hcnt_q == HCNT_LAST) begin
                state_d = ST_READY;
            end
        end
    end

    // Global clear: not ready, lock lost, or explicit phase sync.
    assign clear_all_c = (state_q != ST_READY) || !lk2_q || bus.sync;

    // Accumulator next state; the carry becomes next cycle's strobe, the
    // fractional remainder stays in the accumulator.
    always_comb begin
        acc_d = acc_q;
        ce_d  = '0;
        sum_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sum_c[i] = {1'b0, acc_q[i]} + {1'b0, bus.inc[i*ACC_W +: ACC_W]};
            if (clear_all_c || !bus.run[i]) begin
                acc_d[i] = '0;
                ce_d[i]  = 1'b0;
            end else begin
                acc_d[i] = sum_c[i][ACC_W-1:0];
                ce_d[i]  = sum_c[i][ACC_W];
            end
        end
    end

    // All state flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lk1_q   <= 1'b0;
            lk2_q   <= 1'b0;
            hcnt_q  <= '0;
            state_q <= ST_HOLD;
            acc_q   <= '0;
            ce_q    <= '0;
        end else begin
            lk1_q   <= lk1_d;
            lk2_q   <= lk2_d;
            hcnt_q  <= hcnt_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            ce_q    <= ce_d;
        end
    end

    assign bus.ce    = ce_q;
    assign bus.ready = (state_q == ST_READY);

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen
//   Randomised scoreboard bench. The reference model derives each strobe from
//   floor arithmetic on the accumulated phase (base + n*inc) rather than a
//   bit-level accumulator, and derives ready from the length of the run of
//   synchronised-lock edges.
module tb_clock_enable_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 10;
    localparam int unsigned H  = 16;
    localparam longint      MODV = longint'(1) << W;

    typedef struct packed {
        logic          ready;
        logic [CH-1:0] ce;
    } exp_t;

    logic clock;
    logic reset;

    clock_enable_gen_if #(.CHANNELS(CH), .ACC_W(W)) bus ();

    clock_enable_gen #(
        .CHANNELS   (CH),
        .ACC_W      (W),
        .HOLD_CYCLES(H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];
    int pulse_cnt[CH];

    // Stimulus values applied on the next step.
    logic          cur_locked;
    int unsigned   cur_inc[CH];
    logic [CH-1:0] cur_run;
    logic          cur_sync;

    // Reference model state.
    int     m_lk1, m_lk2, m_ready, m_run_len;
    longint m_base[CH], m_n[CH], m_inc[CH];

    task automatic model_reset();
        m_lk1 = 0; m_lk2 = 0; m_ready = 0; m_run_len = 0;
        for (int i = 0; i < int'(CH); i++) begin
            m_base[i] = 0; m_n[i] = 0; m_inc[i] = 0;
        end
    endtask

    // Expected outputs after the coming edge, from the inputs about to be applied.
    task automatic model_edge(output exp_t e);
        int ready_pre, lk2_pre;
        ready_pre = m_ready;
        lk2_pre   = m_lk2;
        e = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (ready_pre == 0 || lk2_pre == 0 || cur_sync || !cur_run[i]) begin
                m_base[i] = 0;
                m_n[i]    = 0;
                m_inc[i]  = longint'(cur_inc[i]);
            end else begin
                if (longint'(cur_inc[i]) != m_inc[i]) begin
                    m_base[i] = (m_base[i] + m_n[i] * m_inc[i]) % MODV;
                    m_n[i]    = 0;
                    m_inc[i]  = longint'(cur_inc[i]);
                end
                m_n[i] = m_n[i] + 1;
                e.ce[i] = (((m_base[i] + m_n[i] * m_inc[i]) / MODV)
                         - ((m_base[i] + (m_n[i] - 1) * m_inc[i]) / MODV)) != 0;
            end
        end
        if (lk2_pre != 0) m_run_len = (m_run_len < 100000) ? m_run_len + 1 : m_run_len;
        else              m_run_len = 0;
        m_ready = (m_run_len >= int'(H)) ? 1 : 0;
        e.ready = (m_ready != 0);
        m_lk2 = m_lk1;
        m_lk1 = cur_locked ? 1 : 0;
    endtask

    // One clock: drive inputs at the falling edge, optionally pulse reset
    // asynchronously mid-cycle, then queue the expected post-edge outputs.
    task automatic step(input bit do_rst);
        exp_t e;
        @(negedge clock);
        bus.locked = cur_locked;
        bus.run    = cur_run;
        bus.sync   = cur_sync;
        for (int i = 0; i < int'(CH); i++) bus.inc[i*W +: W] = W'(cur_inc[i]);
        if (do_rst) begin
            #1 reset = 1'b1;
            #1;
            checks++;
            if (bus.ready !== 1'b0 || bus.ce !== '0) begin
                failures++;
                $display("FAIL async_reset t=%0t actual ready=%b ce=%b required ready=0 ce=0",
                         $time, bus.ready, bus.ce);
            end
            #1 reset = 1'b0;
            model_reset();
        end
        model_edge(e);
        exp_q.push_back(e);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < int'(CH); i++) pulse_cnt[i] = 0;
    endtask

    task automatic check_count(input string name, input int ch, input int want);
        checks++;
        if (pulse_cnt[ch] != want) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, pulse_cnt[ch], want);
        end
    endtask

    // Monitor: compare every post-edge output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ready !== e.ready || bus.ce !== e.ce) begin
                    failures++;
                    $display("FAIL out_cmp t=%0t actual ready=%b ce=%b required ready=%b ce=%b",
                             $time, bus.ready, bus.ce, e.ready, e.ce);
                end
                for (int i = 0; i < int'(CH); i++) if (bus.ce[i] === 1'b1) pulse_cnt[i]++;
            end
        end
    end

    initial begin
        int lock_low;
        reset      = 1'b1;
        cur_locked = 1'b1;
        cur_sync   = 1'b0;
        cur_run    = '1;
        cur_inc[0] = 256;          // divide by 4
        cur_inc[1] = 18;           // fractional, spacing 56/57
        cur_inc[2] = $urandom_range(1, 1023);
        cur_inc[3] = 0;            // never strobes
        bus.locked = 1'b1;
        bus.sync   = 1'b0;
        bus.run    = cur_run;
        bus.inc    = '0;
        model_reset();
        clear_counts();
        #17 reset = 1'b0;

        // Hold time then a 400-edge integer/fractional/zero window.
        repeat (18) step(1'b0);
        clear_counts();
        repeat (400) step(1'b0);
        @(posedge clock); #2;
        check_count("div4_400", 0, 100);
        check_count("frac18_400", 1, 7);
        check_count("inc0_400", 3, 0);

        // Sync, then one full accumulator period with the extreme increment.
        cur_sync = 1'b1;
        cur_inc[3] = 1023;
        step(1'b0);
        cur_sync = 1'b0;
        clear_counts();
        repeat (1024) step(1'b0);
        @(posedge clock); #2;
        check_count("div4_period", 0, 256);
        check_count("frac18_period", 1, 18);
        check_count("incmax_period", 3, 1023);

        // Randomised traffic: inc changes, run toggles, sync pulses, lock
        // drops and one asynchronous reset.
        lock_low = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                int c;
                c = $urandom_range(0, CH - 1);
                case ($urandom_range(0, 3))
                    0:       cur_inc[c] = 0;
                    1:       cur_inc[c] = 1023;
                    default: cur_inc[c] = $urandom_range(0, 1023);
                endcase
            end
            if ($urandom_range(0, 39) == 0) cur_run[$urandom_range(0, CH - 1)] ^= 1'b1;
            cur_sync = ($urandom_range(0, 99) == 0);
            if (lock_low > 0) begin
                lock_low--;
                cur_locked = (lock_low == 0);
            end else if ($urandom_range(0, 499) == 0) begin
                lock_low   = $urandom_range(1, 6);
                cur_locked = 1'b0;
            end
            step(k == 2000);
        end
        cur_sync = 1'b0;

        // Bounded drain of the scoreboard.
        repeat (4) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
# clock_enable_gen

Multi-channel fractional clock-enable generator with PLL-lock-gated reset release. It sits directly after the board PLL and runs on one PLL output, `clock` (typically 100 MHz). It derives N independent single-cycle enable strobes of programmable average frequency, for example the CPU, pixel, PS/2 and SD enables, and a `ready` flag that downstream logic uses as its release-from-reset. All consumers stay in the one `clock` domain and gate on `ce[i]` instead of using extra PLL outputs.

## Interface
- `CHANNELS`, default 4: number of independent enable channels (1..16).
- `ACC_W`, default 24: phase-accumulator width; output frequency is f_clock·inc/2^ACC_W.
- `HOLD_CYCLES`, default 1024: clocks `locked` must stay high (after synchronisation) before `ready` asserts; at least 1.
- `clock`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: reset, asynchronous and active-high.
- `locked`, in, 1: PLL lock, asynchronous to `clock`.
- `inc`, in, CHANNELS·ACC_W: per-channel increment; channel i is `inc[i*ACC_W +: ACC_W]`. Sampled every cycle, so it may change on the fly.
- `run`, in, CHANNELS: per-channel enable.
- `sync`, in, 1: synchronous phase clear of all accumulators.
- `ce`, out, CHANNELS: registered one-cycle enable strobes.
- `ready`, out, 1: registered; high means lock is stable and the hold time has elapsed.

## Operation
- Lock synchroniser: two flops, `lk1` then `lk2`. `lk2` is the only internal view of `locked`.
- Hold counter `hcnt`, width $clog2(HOLD_CYCLES)+1:
  - If `lk2`=0: `hcnt`←0 and `ready`←0.
  - If `lk2`=1 and `ready`=0: `hcnt`←`hcnt`+1. `ready`←1 on the edge where `hcnt`==HOLD_CYCLES-1.
  - Once `ready`=1, `hcnt` holds. `ready` stays 1 until `lk2` falls.
- `ready` is a two-state FSM: HOLD → READY on the terminal count; READY → HOLD on `lk2`=0.
- Per channel i, the accumulator `acc[i]` is ACC_W bits. Each edge applies the first matching case:
  1. `ready`=0, or `lk2`=0, or `sync`=1, or `run[i]`=0: `acc[i]`←0 and `ce[i]`←0.
  2. Otherwise: {carry, sum} = `acc[i]` + `inc[i]`, ACC_W+1 bits. `acc[i]`←sum and `ce[i]`←carry.
- The carry is never lost. The fractional remainder stays in `acc`, so long-term frequency is exact and jitter is at most 1 `clock`.
- `inc[i]`=0 means `ce[i]` is never asserted.
- `inc[i]`=2^ACC_W-1 means `ce[i]` is high on all accumulate edges except one in every 2^ACC_W.
- Channels are fully independent, except that `sync` and loss of lock act on all channels at once.
- `ce` is never asserted in a cycle where `ready`=0.

## Timing
- Reset values (asynchronous): `lk1`=`lk2`=0, `hcnt`=0, `ready`=0, all `acc`=0, all `ce`=0.
- `ready` latency: `locked` high before edge k means `lk2`=1 after edge k+1. `ready` rises after edge k+1+HOLD_CYCLES.
- Accumulation begins on the first edge on which `ready` is already 1.
- `ce[i]` latency: registered from that edge's carry, so it is visible in the following cycle and lasts exactly one clock per overflow.
- Loss of lock: `locked` falling is seen at `lk2` two edges later. On that same edge `ready`, all `acc` and all `ce` clear. No further strobe is emitted.
- `sync` and an overflow on the same edge: `sync` wins, so there is no strobe.
- `run[i]` falling: the clear applies on that edge. A strobe already registered completes its single cycle.
- `reset` mid-operation: everything returns to reset values immediately (asynchronously), and the full hold time is required again.
- `inc` change mid-run: the new value is used from the next edge. `acc` is not cleared.

## Test plan
1. Reset and hold, with HOLD_CYCLES=16 and `locked`=1 from time 0, `reset` released before edge 1:
   - `ready`=0 and `ce`=0 through edge 17.
   - `ready`=1 after edge 18.
2. Integer divide, with ACC_W=24, `inc[0]`=24'h400000, `run[0]`=1:
   - `ce[0]` first high after the 4th accumulate edge, then exactly every 4 clocks.
   - 100 pulses in 400 cycles.
3. Fractional divide, with `inc[1]`=24'h048D16 (about 1.777 MHz at 100 MHz):
   - Pulse spacing is only 56 or 57 clocks.
   - Over 2^24 clocks, the pulse count equals 0x048D16 exactly.
4. Loss of lock, with `locked` dropped mid-run:
   - Two edges later `ready`=0 and `ce`=0, and they stay 0.
   - After `locked` returns, `ready` re-asserts after HOLD_CYCLES+2 edges and channel phase restarts from 0.
5. `sync` and `run`:
   - Pulse `sync` for one cycle on the edge where channel 0 would overflow: no strobe, and the next strobe comes 4 clocks after `sync` deasserts.
   - `run[2]`=0: `ce[2]` stays 0 while other channels are unaffected.
6. Edge increments:
   - `inc[3]`=0: no strobe in 10 000 cycles.
   - `inc[3]`=24'hFFFFFF: `ce[3]` high on 2^24-1 of every 2^24 accumulate edges.
   - Asynchronous `reset` pulse mid-stream: all outputs are 0 immediately.
